// File: rtl/avalon_lda_queue_controller_pkg.sv
// Shared definitions for the queued line-draw accelerator controller:
// register map, MODE/STATUS bit positions, command layout, dispatcher states.
package lda_pkg;

   // Avalon word addresses
   localparam logic [2:0] ADDR_MODE     = 3'd0;
   localparam logic [2:0] ADDR_STATUS   = 3'd1;
   localparam logic [2:0] ADDR_GO       = 3'd2;
   localparam logic [2:0] ADDR_START    = 3'd3;
   localparam logic [2:0] ADDR_END      = 3'd4;
   localparam logic [2:0] ADDR_COLOR    = 3'd5;
   localparam logic [2:0] ADDR_DONE_CNT = 3'd6;
   localparam logic [2:0] ADDR_RSVD     = 3'd7;

   // MODE bits
   localparam int MODE_POLL_BIT   = 0;
   localparam int MODE_IRQ_EN_BIT = 1;

   // STATUS bits
   localparam int STAT_BUSY_BIT = 0;
   localparam int STAT_FULL_BIT = 1;
   localparam int STAT_OVF_BIT  = 2;
   localparam int STAT_IRQ_BIT  = 3;
   localparam int STAT_OCC_LSB  = 8;

   // Dispatcher states
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DRAW = 2'd2} lda_state_e;
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DRAW  = DRAW;

   // Command layout at the default geometry; the controller builds the same
   // layout from its own X_W/Y_W/C_W parameters.
   localparam int LDA_X_W = 9;
   localparam int LDA_Y_W = 8;
   localparam int LDA_C_W = 3;
   typedef struct packed {
      logic [LDA_X_W-1:0] x0;
      logic [LDA_Y_W-1:0] y0;
      logic [LDA_X_W-1:0] x1;
      logic [LDA_Y_W-1:0] y1;
      logic [LDA_C_W-1:0] color;
   } lda_cmd_t;

endpackage

// File: rtl/avalon_lda_queue_controller_if.sv
// Avalon-MM slave bus of the line-draw controller, plus dispatcher state
// for observation.
// Handshake: a write completes on the first rising edge where s_write is high
// and s_waitrequest is low; the master holds address/data/s_write stable
// while s_waitrequest is high. Reads complete in the same cycle (s_readdata
// is combinational and 0 when s_read is low).
interface avalon_lda_queue_controller_if;
   logic [2:0]  s_address;
   logic        s_read;
   logic [31:0] s_readdata;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        s_waitrequest;
   logic [1:0]  dbg_state;

   modport master (output s_address, s_read, s_write, s_writedata,
                   input  s_readdata, s_waitrequest, dbg_state);
   modport slave  (input  s_address, s_read, s_write, s_writedata,
                   output s_readdata, s_waitrequest, dbg_state);
endinterface

// File: rtl/avalon_lda_queue_controller_fifo.sv
// Synchronous command FIFO. A push while full is accepted only together with
// a pop in the same cycle (the slot being read is the one overwritten).
module lda_cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);

   // Storage, pointers and occupancy; everything clears on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/avalon_lda_queue_controller.sv
// Avalon-MM front end for the line-draw accelerator: staging registers, a
// command FIFO fed by GO writes, and a dispatcher that hands one command at a
// time to the LDA and counts completions.
module avalon_lda_queue_controller
   import lda_pkg::*;
#(
   parameter int X_W   = 9,
   parameter int Y_W   = 8,
   parameter int C_W   = 3,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   avalon_lda_queue_controller_if.slave     bus,
   output logic                             o_irq,
   input  logic                             i_done,
   output logic                             o_start,
   output logic [X_W-1:0]                   o_x0,
   output logic [Y_W-1:0]                   o_y0,
   output logic [X_W-1:0]                   o_x1,
   output logic [Y_W-1:0]                   o_y1,
   output logic [C_W-1:0]                   o_color
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [X_W-1:0] x0;
      logic [Y_W-1:0] y0;
      logic [X_W-1:0] x1;
      logic [Y_W-1:0] y1;
      logic [C_W-1:0] color;
   } cmd_t;

   logic [1:0]     mode;
   logic [X_W-1:0] x0_q, x1_q;
   logic [Y_W-1:0] y0_q, y1_q;
   logic [C_W-1:0] color_q;
   logic           overflow;
   logic           irq_pend;
   logic [CNT_W-1:0] done_cnt;
   logic [1:0]     state;

   cmd_t           push_cmd, pop_cmd;
   logic           fifo_full, fifo_empty;
   logic [AW:0]    fifo_count;
   logic           wr_go, wr_status, pop, push, blocked, drop, draw_done;
   logic [31:0]    rdata;

   assign wr_go     = bus.s_write && (bus.s_address == ADDR_GO);
   assign wr_status = bus.s_write && (bus.s_address == ADDR_STATUS);
   assign pop       = (state == S_IDLE) && !fifo_empty;
   assign blocked   = wr_go && fifo_full && !pop;
   assign push      = wr_go && !blocked;
   assign drop      = blocked && mode[MODE_POLL_BIT];
   assign draw_done = (state == S_DRAW) && i_done;
   assign push_cmd  = {x0_q, y0_q, x1_q, y1_q, color_q};

   assign bus.s_waitrequest = blocked && !mode[MODE_POLL_BIT];
   assign bus.s_readdata    = rdata;
   assign bus.dbg_state     = state;
   assign o_start           = (state == S_START);
   assign o_irq             = irq_pend;

   lda_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (push_cmd),
      .dout  (pop_cmd),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // MODE and staging registers take the masked write data directly.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode    <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
      end else if (bus.s_write) begin
         case (bus.s_address)
            ADDR_MODE:  mode <= bus.s_writedata[1:0];
            ADDR_START: begin
               x0_q <= bus.s_writedata[X_W-1:0];
               y0_q <= bus.s_writedata[X_W+Y_W-1:X_W];
            end
            ADDR_END: begin
               x1_q <= bus.s_writedata[X_W-1:0];
               y1_q <= bus.s_writedata[X_W+Y_W-1:X_W];
            end
            ADDR_COLOR: color_q <= bus.s_writedata[C_W-1:0];
            default: ;
         endcase
      end
   end

   // Sticky flags (set beats write-1-to-clear) and the completion counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         irq_pend <= 1'b0;
         done_cnt <= '0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         else if (wr_status && bus.s_writedata[STAT_OVF_BIT])
            overflow <= 1'b0;

         if (draw_done && mode[MODE_IRQ_EN_BIT])
            irq_pend <= 1'b1;
         else if (wr_status && bus.s_writedata[STAT_IRQ_BIT])
            irq_pend <= 1'b0;

         if (bus.s_write && (bus.s_address == ADDR_DONE_CNT))
            done_cnt <= '0;
         else if (draw_done)
            done_cnt <= done_cnt + 1'b1;
      end
   end

   // Dispatcher: pop in IDLE, pulse start for one cycle, wait for done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         o_x0    <= '0;
         o_y0    <= '0;
         o_x1    <= '0;
         o_y1    <= '0;
         o_color <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  o_x0    <= pop_cmd.x0;
                  o_y0    <= pop_cmd.y0;
                  o_x1    <= pop_cmd.x1;
                  o_y1    <= pop_cmd.y1;
                  o_color <= pop_cmd.color;
                  state   <= S_START;
               end
            end
            S_START: state <= S_DRAW;
            S_DRAW:  if (i_done) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Combinational read mux; idle bus reads as zero.
   always_comb begin
      rdata = '0;
      if (bus.s_read) begin
         case (bus.s_address)
            ADDR_MODE:     rdata[1:0] = mode;
            ADDR_STATUS: begin
               rdata[STAT_BUSY_BIT]         = !fifo_empty || (state != S_IDLE);
               rdata[STAT_FULL_BIT]         = fifo_full;
               rdata[STAT_OVF_BIT]          = overflow;
               rdata[STAT_IRQ_BIT]          = irq_pend;
               rdata[STAT_OCC_LSB +: 8]     = 8'(fifo_count);
            end
            ADDR_START:    rdata[X_W+Y_W-1:0] = {y0_q, x0_q};
            ADDR_END:      rdata[X_W+Y_W-1:0] = {y1_q, x1_q};
            ADDR_COLOR:    rdata[C_W-1:0]     = color_q;
            ADDR_DONE_CNT: rdata[CNT_W-1:0]   = done_cnt;
            default:       rdata = '0;
         endcase
      end
   end
endmodule
